// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer for the bus datapath: turns one LOAD / ALU /
// ALU_WIDE command into the per-step MDR/Y/Z/HI/LO/register strobe pattern.
module alu_op_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5,
  parameter int DW    = 32
) (
  input  logic             i_clock,
  input  logic             i_clear,
  input  logic             i_start,
  input  logic [1:0]       i_cmd,
  input  logic [OPW-1:0]   i_op,
  input  logic [3:0]       i_ra,
  input  logic [3:0]       i_rb,
  input  logic [3:0]       i_rc,
  input  logic [DW-1:0]    i_imm,
  output logic [DW-1:0]    o_mdatain,
  output logic             o_read,
  output logic             o_mdrin,
  output logic             o_mdrout,
  output logic             o_yin,
  output logic             o_zhighin,
  output logic             o_zlowin,
  output logic             o_zhighout,
  output logic             o_zlowout,
  output logic             o_hiin,
  output logic             o_loin,
  output logic [NREGS-1:0] o_rout,
  output logic [NREGS-1:0] o_rin,
  output logic [OPW-1:0]   o_op_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [2:0]       o_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LD_MDR = 3'd1;
  localparam logic [2:0] S_LD_REG = 3'd2;
  localparam logic [2:0] S_T_Y    = 3'd3;
  localparam logic [2:0] S_T_OP   = 3'd4;
  localparam logic [2:0] S_T_ZLO  = 3'd5;
  localparam logic [2:0] S_T_ZHI  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [1:0] C_LOAD  = 2'b00;
  localparam logic [1:0] C_WIDE  = 2'b10;
  localparam logic [1:0] C_RSVD  = 2'b11;

  logic [2:0]       r_state;
  logic [1:0]       r_cmd;
  logic [OPW-1:0]   r_op;
  logic [3:0]       r_ra;
  logic [3:0]       r_rb;
  logic [3:0]       r_rc;
  logic [DW-1:0]    r_imm;
  logic             r_err;

  logic [NREGS-1:0] w_ra_oh;
  logic [NREGS-1:0] w_rb_oh;
  logic [NREGS-1:0] w_rc_oh;

  assign w_ra_oh = NREGS'(1) << r_ra;
  assign w_rb_oh = NREGS'(1) << r_rb;
  assign w_rc_oh = NREGS'(1) << r_rc;

  // Start is only looked at in IDLE, so requests during a command are dropped.
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_imm   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_cmd == C_RSVD) begin
              r_err <= 1'b1;
            end else begin
              r_cmd   <= i_cmd;
              r_op    <= i_op;
              r_ra    <= i_ra;
              r_rb    <= i_rb;
              r_rc    <= i_rc;
              r_imm   <= i_imm;
              r_state <= (i_cmd == C_LOAD) ? S_LD_MDR : S_T_Y;
            end
          end
        end
        S_LD_MDR: r_state <= S_LD_REG;
        S_LD_REG: r_state <= S_DONE;
        S_T_Y:    r_state <= S_T_OP;
        S_T_OP:   r_state <= S_T_ZLO;
        S_T_ZLO:  r_state <= (r_cmd == C_WIDE) ? S_T_ZHI : S_DONE;
        S_T_ZHI:  r_state <= S_DONE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode: every strobe is a function of registered state and fields.
  always_comb begin
    o_mdatain  = '0;
    o_read     = 1'b0;
    o_mdrin    = 1'b0;
    o_mdrout   = 1'b0;
    o_yin      = 1'b0;
    o_zhighin  = 1'b0;
    o_zlowin   = 1'b0;
    o_zhighout = 1'b0;
    o_zlowout  = 1'b0;
    o_hiin     = 1'b0;
    o_loin     = 1'b0;
    o_rout     = '0;
    o_rin      = '0;
    o_op_out   = '0;
    o_done     = 1'b0;
    case (r_state)
      S_LD_MDR: begin
        o_mdatain = r_imm;
        o_read    = 1'b1;
        o_mdrin   = 1'b1;
      end
      S_LD_REG: begin
        o_mdatain = r_imm;
        o_mdrout  = 1'b1;
        o_rin     = w_rc_oh;
      end
      S_T_Y: begin
        o_rout = w_ra_oh;
        o_yin  = 1'b1;
      end
      S_T_OP: begin
        o_rout    = w_rb_oh;
        o_op_out  = r_op;
        o_zhighin = 1'b1;
        o_zlowin  = 1'b1;
      end
      S_T_ZLO: begin
        o_zlowout = 1'b1;
        if (r_cmd == C_WIDE) o_loin = 1'b1;
        else                 o_rin  = w_rc_oh;
      end
      S_T_ZHI: begin
        o_zhighout = 1'b1;
        o_hiin     = 1'b1;
      end
      S_DONE: begin
        // Immediate stays on the MDR mux until IDLE only for LOAD commands.
        if (r_cmd == C_LOAD) o_mdatain = r_imm;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_err   = r_err;
  assign o_state = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed command checks plus randomized
// back-to-back traffic compared each cycle against a per-step strobe model.
module tb_alu_op_sequencer;

  localparam int NREGS = 16;
  localparam int OPW   = 5;
  localparam int DW    = 32;
  localparam int W     = 83;

  // clock / reset
  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [1:0]       cmd = '0;
  logic [OPW-1:0]   op = '0;
  logic [3:0]       ra = '0, rb = '0, rc = '0;
  logic [DW-1:0]    imm = '0;

  logic [DW-1:0]    o_mdatain;
  logic             o_read, o_mdrin, o_mdrout, o_yin, o_zhighin, o_zlowin;
  logic             o_zhighout, o_zlowout, o_hiin, o_loin;
  logic [NREGS-1:0] o_rout, o_rin;
  logic [OPW-1:0]   o_op_out;
  logic             o_busy, o_done, o_err;
  logic [2:0]       o_state;

  alu_op_sequencer #(.NREGS(NREGS), .OPW(OPW), .DW(DW)) dut (
    .i_clock(clk), .i_clear(clear), .i_start(start), .i_cmd(cmd), .i_op(op),
    .i_ra(ra), .i_rb(rb), .i_rc(rc), .i_imm(imm),
    .o_mdatain(o_mdatain), .o_read(o_read), .o_mdrin(o_mdrin), .o_mdrout(o_mdrout),
    .o_yin(o_yin), .o_zhighin(o_zhighin), .o_zlowin(o_zlowin),
    .o_zhighout(o_zhighout), .o_zlowout(o_zlowout), .o_hiin(o_hiin), .o_loin(o_loin),
    .o_rout(o_rout), .o_rin(o_rin), .o_op_out(o_op_out),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_state(o_state)
  );

  logic [W-2:0] w_act;
  assign w_act = {o_busy, o_done, o_err, o_mdatain, o_read, o_mdrin, o_mdrout,
                  o_yin, o_zhighin, o_zlowin, o_zhighout, o_zlowout, o_hiin, o_loin,
                  o_rout, o_rin, o_op_out};

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [W-2:0] act, input logic [W-2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output vector for one cycle; bit W-1 marks an IDLE cycle.
  function automatic logic [W-1:0] vec(
      input logic idle, input logic busy, input logic done, input logic err,
      input logic [DW-1:0] mdat, input logic read, input logic mdrin, input logic mdrout,
      input logic yin, input logic zhin, input logic zlin, input logic zhout,
      input logic zlout, input logic hiin, input logic loin,
      input logic [NREGS-1:0] rout, input logic [NREGS-1:0] rin, input logic [OPW-1:0] opo);
    return {idle, busy, done, err, mdat, read, mdrin, mdrout, yin, zhin, zlin,
            zhout, zlout, hiin, loin, rout, rin, opo};
  endfunction

  function automatic logic [NREGS-1:0] oh(input logic [3:0] idx);
    logic [NREGS-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  // scoreboard: the command's step sequence is queued on accept
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;
  logic [W-1:0] idle_vec;
  assign idle_vec = vec(1,0,0,0,'0,0,0,0,0,0,0,0,0,0,0,'0,'0,'0);

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      exp_q.delete();
      cur = vec(1,0,0,0,'0,0,0,0,0,0,0,0,0,0,0,'0,'0,'0);
    end else begin
      if (cur[W-1] && start) begin
        if (cmd == 2'b11) begin
          exp_q.push_back(vec(1,0,0,1,'0,0,0,0,0,0,0,0,0,0,0,'0,'0,'0));
        end else if (cmd == 2'b00) begin
          exp_q.push_back(vec(0,1,0,0,imm,1,1,0,0,0,0,0,0,0,0,'0,'0,'0));
          exp_q.push_back(vec(0,1,0,0,imm,0,0,1,0,0,0,0,0,0,0,'0,oh(rc),'0));
          exp_q.push_back(vec(0,1,1,0,imm,0,0,0,0,0,0,0,0,0,0,'0,'0,'0));
        end else begin
          exp_q.push_back(vec(0,1,0,0,'0,0,0,0,1,0,0,0,0,0,0,oh(ra),'0,'0));
          exp_q.push_back(vec(0,1,0,0,'0,0,0,0,0,1,1,0,0,0,0,oh(rb),'0,op));
          if (cmd == 2'b10) begin
            exp_q.push_back(vec(0,1,0,0,'0,0,0,0,0,0,0,0,1,0,1,'0,'0,'0));
            exp_q.push_back(vec(0,1,0,0,'0,0,0,0,0,0,0,1,0,1,0,'0,'0,'0));
          end else begin
            exp_q.push_back(vec(0,1,0,0,'0,0,0,0,0,0,0,0,1,0,0,'0,oh(rc),'0));
          end
          exp_q.push_back(vec(0,1,1,0,'0,0,0,0,0,0,0,0,0,0,0,'0,'0,'0));
        end
      end
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_vec;
    end
  end

  // per-cycle compare plus bus invariants
  always @(negedge clk) begin
    int drivers;
    if (clear) begin
      chk("model_vs_dut", w_act, cur[W-2:0]);
      drivers = int'(o_mdrout) + int'(o_zhighout) + int'(o_zlowout) + $countones(o_rout);
      chk("one_bus_driver", W'(drivers <= 1), W'(1));
      chk("rout_onehot0", W'($onehot0(o_rout)), W'(1));
      chk("rin_onehot0", W'($onehot0(o_rin)), W'(1));
    end
  end

  // driver tasks
  task automatic drive_cmd(input logic [1:0] c, input logic [OPW-1:0] o,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input logic [DW-1:0] im);
    @(negedge clk);
    start = 1'b1; cmd = c; op = o; ra = a; rb = b; rc = d; imm = im;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int k;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_done) begin k = i; break; end
    end
    chk(name, W'(k), W'(lat));
    @(negedge clk);
  endtask

  initial begin
    int dones;
    repeat (3) @(negedge clk);
    chk("reset_outputs", w_act, '0);
    chk("reset_state", W'(o_state), '0);
    clear = 1'b1;
    repeat (2) @(negedge clk);

    // LOAD R3 = -12
    drive_cmd(2'b00, 5'd0, 4'd0, 4'd0, 4'd3, 32'hFFFFFFF4);
    @(negedge clk);
    chk("ld_read", W'({o_read, o_mdrin}), W'(2'b11));
    chk("ld_mdatain", W'(o_mdatain), W'(32'hFFFFFFF4));
    @(negedge clk);
    chk("ld_mdrout", W'(o_mdrout), W'(1));
    chk("ld_rin", W'(o_rin), W'(16'h0008));
    @(negedge clk);
    chk("ld_done", W'({o_done, o_busy}), W'(2'b11));
    @(negedge clk);
    chk("ld_idle_mdat", W'({o_busy, o_mdatain}), '0);

    drive_cmd(2'b00, 5'd0, 4'd0, 4'd0, 4'd2, 32'd5);
    wait_done("ld_latency", 3);

    // ALU rol R1 = R4 rol R2
    drive_cmd(2'b01, 5'b00110, 4'd4, 4'd2, 4'd1, 32'd0);
    @(negedge clk);
    chk("rol_ty", W'({o_rout, o_yin}), W'({16'h0010, 1'b1}));
    @(negedge clk);
    chk("rol_top", W'({o_rout, o_op_out, o_zhighin, o_zlowin}),
        W'({16'h0004, 5'b00110, 2'b11}));
    @(negedge clk);
    chk("rol_tzlo", W'({o_zlowout, o_rin, o_loin}), W'({1'b1, 16'h0002, 1'b0}));
    @(negedge clk);
    chk("rol_done", W'(o_done), W'(1));
    @(negedge clk);

    // ALU_WIDE
    drive_cmd(2'b10, 5'd7, 4'd2, 4'd4, 4'd9, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wide_tzlo", W'({o_zlowout, o_loin, o_rin}), W'({2'b11, 16'h0}));
    @(negedge clk);
    chk("wide_tzhi", W'({o_zhighout, o_hiin, o_rin}), W'({2'b11, 16'h0}));
    @(negedge clk);
    chk("wide_done", W'(o_done), W'(1));
    @(negedge clk);
    drive_cmd(2'b10, 5'd3, 4'd1, 4'd1, 4'd1, 32'd0);
    wait_done("wide_latency", 5);
    drive_cmd(2'b01, 5'd2, 4'd5, 4'd5, 4'd5, 32'd0);
    wait_done("alu_latency", 4);

    // reserved command
    drive_cmd(2'b11, 5'd0, 4'd0, 4'd0, 4'd0, 32'd0);
    @(negedge clk);
    chk("err_pulse", W'({o_err, o_busy}), W'(2'b10));
    @(negedge clk);
    chk("err_once", W'({o_err, o_busy}), '0);

    // start held through an ALU command
    @(negedge clk);
    start = 1'b1; cmd = 2'b01; op = 5'd1; ra = 4'd7; rb = 4'd8; rc = 4'd9;
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (o_done) dones++;
      if (i == 4) start = 1'b0;
      if (i == 5) chk("no_queued_cmd", W'(o_busy), '0);
    end
    chk("one_cmd_executed", W'(dones), W'(1));

    // reset mid T_OP
    drive_cmd(2'b01, 5'd6, 4'd3, 4'd4, 4'd5, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 clear = 1'b0;
    #1;
    chk("reset_mid_cmd", w_act, '0);
    chk("reset_mid_state", W'(o_state), '0);
    @(negedge clk);
    #1 clear = 1'b1;
    repeat (4) @(negedge clk);

    // randomized back-to-back traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      cmd = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      op = 5'($urandom);
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      imm = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Hardwired control sequencer for the 32-bit bus datapath (`data_path`).
- Accepts one command per start pulse: register load-immediate, two-operand ALU op, or wide (HI/LO) ALU op.
- Emits the one-cycle-per-step strobe pattern the datapath needs: MDR/Y/Z/register in/out enables plus the ALU opcode.
- Replaces the hand-written state sequencing in the testbenches; sits between the future instruction decoder and `data_path`.

Parameters:
- NREGS, 16, number of general registers; width of the one-hot Rout/Rin vectors.
- OPW, 5, ALU opcode width.
- DW, 32, datapath/immediate width.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous reset, active-low; 0 forces IDLE immediately.
- start  in  1  command request; sampled only in IDLE.
- cmd  in  2  00 LOAD, 01 ALU, 10 ALU_WIDE, 11 reserved.
- op  in  OPW  ALU opcode (e.g. 00110 = rol).
- ra  in  4  first source register index.
- rb  in  4  second source register index.
- rc  in  4  destination register index.
- imm  in  DW  immediate for LOAD.
- Mdatain  out  DW  immediate presented to MDR mux.
- Read  out  1  MDR selects Mdatain.
- MDRin  out  1  MDR load enable.
- MDRout  out  1  MDR drives bus.
- Yin  out  1  Y load enable.
- ZHighin  out  1  Z high load enable.
- Zlowin  out  1  Z low load enable.
- Zhighout  out  1  Z high drives bus.
- Zlowout  out  1  Z low drives bus.
- HIin  out  1  HI load enable.
- LOin  out  1  LO load enable.
- Rout  out  NREGS  one-hot register-to-bus select.
- Rin  out  NREGS  one-hot register load enables.
- op_out  out  OPW  opcode to ALU.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on reserved cmd.

Behaviour:
- Reset (clear=0, async): state=IDLE; every output 0, including Mdatain, Rout, Rin, op_out, busy, done, err; latched fields cleared. Reset mid-command abandons it; no further strobes after reset deasserts.
- Outputs are Moore, decoded from registered state plus latched fields. Each is stable for the whole cycle and captured by the datapath on the following rising edge.
- Accept: in IDLE with start=1 and cmd≠11, latch cmd/op/ra/rb/rc/imm on that edge; busy=1 from the next cycle through DONE inclusive.
- start while busy: ignored, never queued.
- IDLE, start=1, cmd=11: stay IDLE; err=1 for exactly one cycle; busy stays 0.
- States and strobes (everything not listed is 0):
  - IDLE: no strobes.
  - LD_MDR: Mdatain=imm_latched, Read=1, MDRin=1.
  - LD_REG: MDRout=1, Rin[rc]=1.
  - T_Y: Rout[ra]=1, Yin=1.
  - T_OP: Rout[rb]=1, op_out=op_latched, ZHighin=1, Zlowin=1.
  - T_ZLO: Zlowout=1. For ALU, Rin[rc]=1; for ALU_WIDE, LOin=1.
  - T_ZHI: Zhighout=1, HIin=1 (ALU_WIDE only).
  - DONE: done=1, busy=1.
- Mdatain holds imm_latched from LD_MDR until IDLE re-entry, then returns to 0.
- Transitions:
  - LOAD: IDLE→LD_MDR→LD_REG→DONE.
  - ALU: IDLE→T_Y→T_OP→T_ZLO→DONE.
  - ALU_WIDE: IDLE→T_Y→T_OP→T_ZLO→T_ZHI→DONE.
  - DONE→IDLE unconditionally. start in DONE is ignored, so the minimum issue gap is one IDLE cycle.
- Latency, accept edge at cycle N: done is high in cycle N+3 (LOAD), N+4 (ALU), N+5 (ALU_WIDE).
- Invariants:
  - At most one bus driver (MDRout, Zhighout, Zlowout, any Rout bit) is high in any cycle.
  - Rout and Rin are never multi-hot.
- ra=rb and ra=rc are legal: the same index is strobed in successive cycles, never simultaneously out and in.
- Unary ops (rol/ror/neg/not) use the same ALU flow; the ALU ignores whichever operand it does not need.

Test Plan:
- Reset: clear=0 mid-T_OP of an ALU command → all outputs 0 immediately. After clear=1, state is IDLE and no Rin pulse occurs.
- LOAD: cmd=00, rc=3, imm=32'hFFFFFFF4 (-12).
  - Next cycle: Read=MDRin=1, Mdatain=FFFFFFF4.
  - Then MDRout=1, Rin=16'h0008.
  - Then done=1.
  - Datapath R3 reads FFFFFFF4.
- ALU rol: preload R2=5, R4=-12 via LOAD, then cmd=01, op=00110, ra=4, rb=2, rc=1.
  - Strobes in order: Rout=0010h+Yin, Rout=0004h+op_out=00110+ZHighin/Zlowin, Zlowout+Rin=0002h.
  - done at N+4; R1 = datapath rol result.
- ALU_WIDE: cmd=10, ra=2, rb=4.
  - T_ZLO shows Zlowout+LOin; T_ZHI shows Zhighout+HIin.
  - Rin stays 0 throughout; done at N+5.
- Reserved/overlap:
  - cmd=11 → err pulse one cycle, busy=0.
  - start asserted every cycle during an ALU command → exactly one command executed. Next accept happens no earlier than the IDLE cycle after DONE.
- Bus invariant: over 200 random back-to-back commands, at most one bus driver per cycle; Rout and Rin always one-hot or zero.
